// File: rtl/seq_add_sub.sv
// Multi-cycle WIDTH-bit add/subtract, one DIGIT-bit slice per clock, LSB slice first.
// Define SEQ_ADD_SUB_SAT_EN to clamp sum to the signed extreme on overflow.
module seq_add_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;

  logic             w_accept;
  logic             w_last;
  logic [DIGIT:0]   w_slice;
  logic [WIDTH-1:0] w_slice_ext;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_sum_final;
  logic             w_ovf;

  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_idx == IDXW'(NDIG - 1));

  // Operands are shifted right each cycle, so the active slice is always the low DIGIT bits.
  assign w_slice     = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
  assign w_slice_ext = WIDTH'(w_slice[DIGIT-1:0]);
  assign w_acc_next  = (r_acc >> DIGIT) | (w_slice_ext << (WIDTH - DIGIT));

  // Carry into the MSB is recovered from the MSB sum bit of the final slice.
  assign w_ovf = w_slice[DIGIT] ^ (r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_slice[DIGIT-1]);

`ifdef SEQ_ADD_SUB_SAT_EN
  assign w_sum_final = w_ovf ? {r_a[DIGIT-1], {(WIDTH-1){~r_a[DIGIT-1]}}} : w_acc_next;
`else
  assign w_sum_final = w_acc_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = start ? S_RUN : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b ^ {WIDTH{sub}};
      r_carry <= sub | cin;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_acc   <= w_acc_next;
      r_carry <= w_slice[DIGIT];
      r_idx   <= r_idx + IDXW'(1);
      if (w_last) begin
        sum  <= w_sum_final;
        cout <= w_slice[DIGIT];
        ovf  <= w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_seq_add_sub.sv
// Bench for seq_add_sub: 16/4 instance plus a degenerate 8/8 instance, checked against
// a plain-arithmetic model. Honours SEQ_ADD_SUB_SAT_EN when defined.
module tb_seq_add_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        start16, start8;
  logic        sub_in, cin_in;
  logic [15:0] a_in, b_in;

  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        sel = 1'b0;
  logic [31:0] prev_sum [2];

  always #5 clk = ~clk;

  seq_add_sub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub_in), .a(a_in), .b(b_in), .cin(cin_in),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  seq_add_sub #(.WIDTH(8), .DIGIT(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub_in), .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  logic        m_busy, m_done, m_cout, m_ovf;
  logic [31:0] m_sum;
  assign m_busy = sel ? busy8 : busy16;
  assign m_done = sel ? done8 : done16;
  assign m_cout = sel ? cout8 : cout16;
  assign m_ovf  = sel ? ovf8 : ovf16;
  assign m_sum  = sel ? {24'b0, sum8} : {16'b0, sum16};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {ovf, cout, sum[31:0]} for a w-bit operation.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic sb);
    logic [63:0] mask, bb, full, s;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    bb   = sb ? (~{32'b0, b} & mask) : {32'b0, b};
    full = {32'b0, a} + bb + {63'b0, (sb | ci)};
    s    = full & mask;
    co   = full[w];
    ov   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
`ifdef SEQ_ADD_SUB_SAT_EN
    if (ov) s = a[w-1] ? (64'd1 << (w - 1)) : ((64'd1 << (w - 1)) - 64'd1);
`endif
    return {ov, co, s[31:0]};
  endfunction

  // Presents operands with start for one edge; returns at the negedge after acceptance.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
    a_in   = a;
    b_in   = b;
    cin_in = ci;
    sub_in = sb;
    if (sel) start8 = 1'b1;
    else     start16 = 1'b1;
    @(negedge clk);
    start8  = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic collect(input string tag, input int exp_busy, input logic [15:0] a,
                         input logic [15:0] b, input logic ci, input logic sb);
    int          w, n;
    logic        hold_ok;
    logic [33:0] e;
    logic [31:0] am, bm;
    w  = sel ? 8 : 16;
    am = sel ? {24'b0, a[7:0]} : {16'b0, a};
    bm = sel ? {24'b0, b[7:0]} : {16'b0, b};
    e  = model(w, am, bm, ci, sb);
    n = 0;
    hold_ok = 1'b1;
    while (m_busy && n < 40) begin
      if (m_sum !== prev_sum[sel] || m_done !== 1'b0) hold_ok = 1'b0;
      n++;
      @(negedge clk);
    end
    check_eq({tag, "_busy_cycles"}, n, exp_busy);
    check_eq({tag, "_hold"}, {31'b0, hold_ok}, 32'd1);
    check_eq({tag, "_done"}, {31'b0, m_done}, 32'd1);
    check_eq({tag, "_sum"}, m_sum, e[31:0]);
    check_eq({tag, "_cout"}, {31'b0, m_cout}, {31'b0, e[32]});
    check_eq({tag, "_ovf"}, {31'b0, m_ovf}, {31'b0, e[33]});
    prev_sum[sel] = e[31:0];
    $display("[TB] %s w=%0d a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d busy=%0d",
             tag, w, am, bm, ci, sb, m_sum, m_cout, m_ovf, n);
  endtask

  task automatic normal_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic ci, input logic sb);
    @(negedge clk);
    check_eq({tag, "_done_fell"}, {31'b0, m_done}, 32'd0);
    launch(a, b, ci, sb);
    collect(tag, sel ? 1 : 4, a, b, ci, sb);
  endtask

  logic [15:0] ta [8] = '{16'h0001, 16'hFFFF, 16'h000F, 16'h7FFF, 16'h8000, 16'h0005, 16'h0005, 16'h8000};
  logic [15:0] tb [8] = '{16'h0002, 16'h0001, 16'h0000, 16'h0001, 16'h0001, 16'h0007, 16'h0007, 16'h8000};
  logic        tc [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        ts [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    logic [15:0] ra, rb;
    logic        rc, rs, seen;
    rst = 1'b1; start16 = 1'b0; start8 = 1'b0;
    a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
    prev_sum[0] = '0; prev_sum[1] = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", {31'b0, busy16}, 32'd0);
    check_eq("rst_done", {31'b0, done16}, 32'd0);
    check_eq("rst_sum", {16'b0, sum16}, 32'd0);
    check_eq("rst_cout_ovf", {30'b0, cout16, ovf16}, 32'd0);
    check_eq("rst_sum8", {24'b0, sum8}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) normal_op($sformatf("dir%0d", i), ta[i], tb[i], tc[i], ts[i]);

    // Start during busy must be ignored without resampling operands.
    @(negedge clk);
    launch(16'h1234, 16'h1111, 1'b0, 1'b0);
    a_in = 16'hFFFF; b_in = 16'hFFFF; sub_in = 1'b1; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    collect("ignore", 3, 16'h1234, 16'h1111, 1'b0, 1'b0);

    // Start in the done cycle: accepted back-to-back.
    launch(16'h4000, 16'h4000, 1'b0, 1'b0);
    collect("b2b", 4, 16'h4000, 16'h4000, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      if (i % 4 == 3) begin
        launch(ra, rb, rc, rs);
        collect($sformatf("rnd_b2b%0d", i), 4, ra, rb, rc, rs);
      end else begin
        normal_op($sformatf("rnd%0d", i), ra, rb, rc, rs);
      end
    end

    // Reset in the second RUN cycle discards the operation.
    @(negedge clk);
    launch(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_busy", {31'b0, busy16}, 32'd0);
    check_eq("midrst_done", {31'b0, done16}, 32'd0);
    check_eq("midrst_sum", {16'b0, sum16}, 32'd0);
    check_eq("midrst_cout_ovf", {30'b0, cout16, ovf16}, 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done16 || busy16) seen = 1'b1;
    end
    check_eq("midrst_no_done", {31'b0, seen}, 32'd0);
    prev_sum[0] = '0;
    prev_sum[1] = '0;

    sel = 1'b1;
    normal_op("deg_7f01", 16'h007F, 16'h0001, 1'b0, 1'b0);
    normal_op("deg_ff01", 16'h00FF, 16'h0001, 1'b0, 1'b0);
    normal_op("deg_sub", 16'h0080, 16'h0001, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      if (i % 3 == 2) begin
        launch(ra, rb, rc, rs);
        collect($sformatf("deg_b2b%0d", i), 1, ra, rb, rc, rs);
      end else begin
        normal_op($sformatf("deg_rnd%0d", i), ra, rb, rc, rs);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
